// File: rtl/latch_sampler.sv
// Brings a D-latch bank's q/en into the clk domain, waits for close + settle, then offers the frozen value on valid/ready.
// Optional define LATCH_SAMPLER_PARITY_EN adds out_par (even-parity bit of the captured value).
module latch_sampler #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] lat_q,
  input  logic             lat_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
`ifdef LATCH_SAMPLER_PARITY_EN
  ,
  output logic             out_par
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t                 state;
  logic [7:0]             cnt;
  logic [WIDTH-1:0]       q_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] en_sync;
  logic                   en_s_d;
  logic [WIDTH-1:0]       q_s;
  logic                   en_s;
  logic                   close;
  logic                   transfer;

  assign q_s      = q_sync[SYNC_STAGES-1];
  assign en_s     = en_sync[SYNC_STAGES-1];
  assign close    = en_s_d & ~en_s;
  assign transfer = out_valid & out_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) q_sync[i] <= '0;
      en_sync <= '0;
      en_s_d  <= 1'b0;
    end else begin
      q_sync[0] <= lat_q;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) q_sync[i] <= q_sync[i-1];
      en_sync <= {en_sync[SYNC_STAGES-2:0], lat_en};
      en_s_d  <= en_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef LATCH_SAMPLER_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (close) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          // Re-opening the latch aborts silently; it takes priority over capture.
          if (en_s) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            out_data  <= q_s;
            out_valid <= 1'b1;
`ifdef LATCH_SAMPLER_PARITY_EN
            out_par   <= ^q_s;
`endif
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (transfer) begin
            out_valid <= 1'b0;
            if (close) begin
              state <= SETTLE;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A dropped close sets overrun even if a clear arrives in the same cycle.
      if (state == HOLD && close && !transfer) overrun <= 1'b1;
      else if (overrun_clr)                     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_latch_sampler.sv
// Directed self-checking bench for latch_sampler: capture table plus abort, overrun, handshake-overlap and reset sequences.
module tb_latch_sampler;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] lat_q = '0;
  logic       lat_en = 1'b0;
  logic       out_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overrun;
  logic       busy;
`ifdef LATCH_SAMPLER_PARITY_EN
  logic       out_par;
`endif

  latch_sampler #(.WIDTH(8), .SYNC_STAGES(2), .SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .lat_q       (lat_q),
    .lat_en      (lat_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
`ifdef LATCH_SAMPLER_PARITY_EN
    ,
    .out_par     (out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] exp_data;
    logic       exp_par;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Opens the latch long enough to propagate, then closes it; returns right at the close.
  task automatic open_close(input logic [7:0] q);
    lat_q  = q;
    lat_en = 1'b1;
    step(3);
    lat_en = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 20 && !out_valid) begin
      step(1);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int n;
    logic seen;

    vecs[0] = '{8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 8'h3C, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b1};
    vecs[4] = '{8'h07, 8'h07, 1'b1};
    vecs[5] = '{8'h03, 8'h03, 1'b0};
    vecs[6] = '{8'hFE, 8'hFE, 1'b1};

    step(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    step(1);

    for (int i = 0; i < 7; i++) begin
      open_close(vecs[i].q);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), lat, 7);
      chk($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("v%0d_busy", i), busy, 1);
`ifdef LATCH_SAMPLER_PARITY_EN
      chk($sformatf("v%0d_par", i), out_par, vecs[i].exp_par);
`endif
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      chk($sformatf("v%0d_valid_drop", i), out_valid, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end

    // Abort: latch re-opens two cycles after the close is detected.
    open_close(8'h55);
    n = 0;
    while (n < 20 && !busy) begin
      step(1);
      n++;
    end
    chk("abort_busy_edge", n, 3);
    step(1);
    lat_en = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      step(1);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_busy", busy, 0);
    chk("abort_overrun", overrun, 0);

    // Overrun: second close while holding an unconsumed value.
    open_close(8'hA5);
    wait_valid(lat);
    chk("ovr_first_data", out_data, 8'hA5);
    open_close(8'h3C);
    step(10);
    chk("ovr_set", overrun, 1);
    chk("ovr_data_frozen", out_data, 8'hA5);
    chk("ovr_valid_held", out_valid, 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Close and clear land on the same edge: the set must win.
    open_close(8'h3C);
    step(2);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("ovr_set_beats_clr", overrun, 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("ovr_clr2", overrun, 0);

    // Transfer and close on the same edge: old value leaves, new event is accepted.
    open_close(8'h3C);
    step(2);
    chk("xc_hold_data", out_data, 8'hA5);
    chk("xc_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("xc_valid_drop", out_valid, 0);
    chk("xc_busy", busy, 1);
    wait_valid(lat);
    chk("xc_latency", lat, 4);
    chk("xc_data", out_data, 8'h3C);
    chk("xc_overrun", overrun, 0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;

    // Reset in the middle of HOLD with overrun set.
    open_close(8'h5A);
    wait_valid(lat);
    chk("prerst_data", out_data, 8'h5A);
    open_close(8'hC3);
    step(10);
    chk("prerst_overrun", overrun, 1);
    rstn = 1'b0;
    step(1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_busy", busy, 0);
    step(1);
    rstn = 1'b1;
    step(3);
    chk("postrst_valid", out_valid, 0);
    chk("postrst_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
